digit_serial_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 14 +
 rtl/nand_full_adder.sv | 22 ++
 rtl/digit_serial_adder.sv | 91 +++++++++
 tb/tb_digit_serial_adder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and parameter legality check for the digit-serial adder
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic bit params_ok(input int width, input int digit);
      return width >= 2 && digit >= 1 && digit < width && (width % digit) == 0;
   endfunction

endpackage

// File: rtl/nand_full_adder.sv
// nand_full_adder: one-bit full adder built from nine 2-input NAND gates
module nand_full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic n1, n2, n3, n4, n5, n6, n7;

   assign n1 = ~(x & y);
   assign n2 = ~(x & n1);
   assign n3 = ~(y & n1);
   assign n4 = ~(n2 & n3);
   assign n5 = ~(n4 & ci);
   assign n6 = ~(n4 & n5);
   assign n7 = ~(ci & n5);
   assign s  = ~(n6 & n7);
   assign co = ~(n5 & n1);

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract of WIDTH-bit operands, DIGIT bits per clock
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
      $fatal(1, "digit_serial_adder: DIGIT must divide WIDTH, DIGIT < WIDTH, WIDTH >= 2");
   end

   state_t             state, state_n;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   a_sr, b_sr, sum_r;
   logic               carry;
   logic [DIGIT-1:0]   ds;
   logic [DIGIT:0]     dc;
   logic               accept, last;

   assign dc[0] = carry;

   for (genvar i = 0; i < DIGIT; i++) begin : g_slice
      nand_full_adder u_fa (
         .x  (a_sr[i]),
         .y  (b_sr[i]),
         .ci (dc[i]),
         .s  (ds[i]),
         .co (dc[i+1])
      );
   end

   assign accept = (state != RUN) && start;
   assign last   = count == CW'(N - 1);

   // next state: RUN lasts exactly N digit edges; start only honoured outside RUN
   always_comb begin
      state_n = state;
      state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // datapath: load operands on accept, then shift one digit per RUN edge into sum from the MSB end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         sum_r <= '0;
         carry <= 1'b0;
         count <= '0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= sub ? ~b : b;
         sum_r <= '0;
         carry <= sub ? 1'b1 : cin;
         count <= '0;
      end else if (state == RUN) begin
         a_sr  <= a_sr >> DIGIT;
         b_sr  <= b_sr >> DIGIT;
         sum_r <= {ds, sum_r[WIDTH-1:DIGIT]};
         carry <= dc[DIGIT];
         count <= count + 1'b1;
      end
   end

   assign busy = state == RUN;
   assign done = state == DONE;
   assign sum  = sum_r;
   assign cout = carry;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed scoreboard bench for DIGIT=1 and DIGIT=4 adders
module tb_digit_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0, start4 = 1'b0;
   logic       sub = 1'b0, cin = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy1, done1, cout1, busy4, done4, cout4;
   logic [7:0] sum1, sum4;
   bit         sel = 1'b0;
   logic       busy_s, done_s, cout_s;
   logic [7:0] sum_s;
   logic [8:0] q[$];
   logic [8:0] last_exp;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   assign busy_s = sel ? busy4 : busy1;
   assign done_s = sel ? done4 : done1;
   assign sum_s  = sel ? sum4  : sum1;
   assign cout_s = sel ? cout4 : cout1;

   function automatic logic [8:0] model(input logic sb, input logic [7:0] aa, bb, input logic ci);
      return sb ? {1'b0, aa} + {1'b0, ~bb} + 9'd1 : {1'b0, aa} + {1'b0, bb} + {8'd0, ci};
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start4 = v;
      else     start1 = v;
   endtask

   task automatic launch(input bit s, input logic sb, input logic [7:0] aa, bb, input logic ci, input bit hold);
      sel = s; sub = sb; a = aa; b = bb; cin = ci;
      set_start(1'b1);
      q.push_back(model(sb, aa, bb, ci));
      @(negedge clk);
      if (!hold) set_start(1'b0);
      chk("busy_after_start", {8'd0, busy_s}, 9'd1);
   endtask

   task automatic wait_done(input int n, input int k0, input string tag);
      int k = k0;
      while (!done_s && k < n + 4) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_latency"}, 9'(k), 9'(n));
      chk({tag, "_busy_in_done"}, {8'd0, busy_s}, 9'd0);
      last_exp = (q.size() > 0) ? q.pop_front() : 9'h1xx;
      chk({tag, "_sum"}, {1'b0, sum_s}, {1'b0, last_exp[7:0]});
      chk({tag, "_cout"}, {8'd0, cout_s}, {8'd0, last_exp[8]});
   endtask

   initial begin
      start1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", {8'd0, busy1}, 9'd0);
      chk("rst_done", {8'd0, done1}, 9'd0);
      chk("rst_sum",  {1'b0, sum1},  9'd0);
      chk("rst_cout", {8'd0, cout1}, 9'd0);
      rst = 1'b0;
      q.push_back(model(1'b0, 8'h00, 8'h00, 1'b0));
      @(negedge clk);
      start1 = 1'b0;
      chk("busy_after_rst_release", {8'd0, busy1}, 9'd1);
      wait_done(8, 0, "zero");
      launch(0, 1'b0, 8'hFF, 8'h01, 1'b0, 0);
      wait_done(8, 0, "add_ff_01");
      launch(0, 1'b1, 8'h05, 8'h07, 1'b1, 0);
      wait_done(8, 0, "sub_5_7");
      launch(0, 1'b1, 8'h07, 8'h05, 1'b0, 0);
      wait_done(8, 0, "sub_7_5");
      repeat (2) @(negedge clk);
      chk("hold_sum",  {1'b0, sum1},  {1'b0, last_exp[7:0]});
      chk("hold_cout", {8'd0, cout1}, {8'd0, last_exp[8]});
      launch(1, 1'b0, 8'h9C, 8'h65, 1'b1, 0);
      wait_done(2, 0, "d4_add");
      launch(1, 1'b1, 8'h40, 8'hC1, 1'b0, 0);
      wait_done(2, 0, "d4_sub");
      launch(0, 1'b0, 8'h12, 8'h34, 1'b0, 0);
      repeat (2) @(negedge clk);
      a = 8'hFF; b = 8'hFF; sub = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done(8, 3, "ignore_start");
      launch(0, 1'b0, 8'h10, 8'h20, 1'b1, 1);
      wait_done(8, 0, "b2b_first");
      launch(0, 1'b0, 8'hA7, 8'h6B, 1'b0, 0);
      chk("b2b_done_low", {8'd0, done1}, 9'd0);
      wait_done(8, 0, "b2b_second");
      launch(0, 1'b0, 8'hAA, 8'h55, 1'b1, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {8'd0, busy1}, 9'd0);
      chk("abort_done", {8'd0, done1}, 9'd0);
      chk("abort_sum",  {1'b0, sum1},  9'd0);
      chk("abort_cout", {8'd0, cout1}, 9'd0);
      void'(q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      launch(0, 1'b0, 8'h3C, 8'h0F, 1'b0, 0);
      wait_done(8, 0, "after_abort");
      repeat (2) @(negedge clk);
      chk("back_to_idle", {7'd0, busy1, done1}, 9'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
